// File: rtl/lane_tx_scheduler_pkg.sv
// Shared symbol codes, FSM encoding and small lane helpers for the lane TX scheduler.
package lane_tx_scheduler_pkg;

  // K-code symbols understood by the serializer and the receiver
  localparam logic [7:0] SYM_COM  = 8'hBC;
  localparam logic [7:0] SYM_IDLE = 8'h7C;

  // Scheduler phases: COM training burst, then arbitration forever
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  // Next lane in round-robin order (wraps 3 -> 0)
  function automatic logic [1:0] lane_inc(input logic [1:0] lane);
    return lane + 2'd1;
  endfunction

  // One-hot ready vector for a lane index
  function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/lane_tx_scheduler_rr_pick4.sv
// Rotating priority encoder: first requesting lane at or after ptr, wrapping mod 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [7:0] req_dbl_s;
  logic [7:0] req_shift_s;
  logic [3:0] rot_s;
  logic [1:0] off_s;

  // Rotate requests so lane ptr sits at bit 0, then take the lowest set bit as an offset
  always_comb begin
    req_dbl_s   = {req, req};
    req_shift_s = req_dbl_s >> ptr;
    rot_s       = req_shift_s[3:0];
    found       = |req;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
    idx = ptr + off_s;
  end

endmodule

// File: rtl/lane_tx_scheduler.sv
// Round-robin byte-lane scheduler feeding the serializer: COM training after reset,
// then one lane grant per strobe with bounded bursts, IDLE fill and an idle indicator.
module lane_tx_scheduler
  import lane_tx_scheduler_pkg::*;
#(
  parameter int unsigned INIT_COM = 4,
  parameter int unsigned BURST    = 2,
  parameter int unsigned IDLE_MIN = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  input  logic [7:0] data_2,
  input  logic [7:0] data_3,
  input  logic       valid_0,
  input  logic       valid_1,
  input  logic       valid_2,
  input  logic       valid_3,
  output logic       ready_0,
  output logic       ready_1,
  output logic       ready_2,
  output logic       ready_3,
  input  logic       ser_ready,
  output logic [7:0] sym_data,
  output logic       sym_k,
  output logic       sym_valid,
  output logic [1:0] sym_lane,
  output logic       idle_out
);

  localparam int unsigned COM_W   = $clog2(INIT_COM + 1);
  localparam int unsigned BURST_W = $clog2(BURST + 1);
  localparam int unsigned IDLE_W  = $clog2(IDLE_MIN + 1);

  localparam logic [COM_W-1:0]   COM_LAST  = COM_W'(INIT_COM - 1);
  localparam logic [COM_W-1:0]   COM_ONE   = COM_W'(1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
  localparam logic [IDLE_W-1:0]  IDLE_SAT  = IDLE_W'(IDLE_MIN);
  localparam logic [IDLE_W-1:0]  IDLE_ONE  = IDLE_W'(1);

  sched_state_t       state_r;
  logic [COM_W-1:0]   com_cnt_r;
  logic [1:0]         rr_ptr_r;
  logic [BURST_W-1:0] burst_cnt_r;
  logic [IDLE_W-1:0]  idle_cnt_r;
  logic [7:0]         sym_data_r;
  logic               sym_k_r;
  logic               sym_valid_r;
  logic [1:0]         sym_lane_r;
  logic               idle_out_r;

  logic [3:0]         req_s;
  logic               found_s;
  logic [1:0]         win_s;
  logic [3:0]         grant_s;
  logic [7:0]         win_data_s;
  logic [BURST_W-1:0] burst_next_s;
  logic [IDLE_W-1:0]  idle_next_s;

  assign req_s = {valid_3, valid_2, valid_1, valid_0};

  rr_pick4 u_pick (
    .req   (req_s),
    .ptr   (rr_ptr_r),
    .found (found_s),
    .idx   (win_s)
  );

  // Select the winning lane's byte and accept it only on a live RUN strobe
  always_comb begin
    grant_s = 4'b0000;
    case (win_s)
      2'd0:    win_data_s = data_0;
      2'd1:    win_data_s = data_1;
      2'd2:    win_data_s = data_2;
      2'd3:    win_data_s = data_3;
      default: win_data_s = data_0;
    endcase
    if (!reset && ser_ready && (state_r == ST_RUN) && found_s) begin
      grant_s = lane_onehot(win_s);
    end else begin
      grant_s = 4'b0000;
    end
  end

  // Burst length after this grant (a streak continues only if the pointer lane wins again)
  // and the saturating IDLE run length after an empty slot
  always_comb begin
    burst_next_s = BURST_ONE;
    idle_next_s  = idle_cnt_r;
    if (win_s == rr_ptr_r) begin
      burst_next_s = burst_cnt_r + BURST_ONE;
    end else begin
      burst_next_s = BURST_ONE;
    end
    if (idle_cnt_r >= IDLE_SAT) begin
      idle_next_s = IDLE_SAT;
    end else begin
      idle_next_s = idle_cnt_r + IDLE_ONE;
    end
  end

  assign ready_0 = grant_s[0];
  assign ready_1 = grant_s[1];
  assign ready_2 = grant_s[2];
  assign ready_3 = grant_s[3];

  // Scheduler FSM, counters and registered symbol outputs; one symbol per strobe
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_r     <= ST_INIT;
      com_cnt_r   <= '0;
      rr_ptr_r    <= 2'd0;
      burst_cnt_r <= '0;
      idle_cnt_r  <= '0;
      sym_data_r  <= 8'h00;
      sym_k_r     <= 1'b0;
      sym_valid_r <= 1'b0;
      sym_lane_r  <= 2'd0;
      idle_out_r  <= 1'b0;
    end else if (ser_ready) begin
      sym_valid_r <= 1'b1;
      case (state_r)
        ST_INIT: begin
          sym_data_r <= SYM_COM;
          sym_k_r    <= 1'b1;
          sym_lane_r <= 2'd0;
          com_cnt_r  <= com_cnt_r + COM_ONE;
          if (com_cnt_r == COM_LAST) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_INIT;
          end
        end
        ST_RUN: begin
          if (found_s) begin
            sym_data_r <= win_data_s;
            sym_k_r    <= 1'b0;
            sym_lane_r <= win_s;
            idle_cnt_r <= '0;
            idle_out_r <= 1'b0;
            if (burst_next_s == BURST_MAX) begin
              rr_ptr_r    <= lane_inc(win_s);
              burst_cnt_r <= '0;
            end else begin
              rr_ptr_r    <= win_s;
              burst_cnt_r <= burst_next_s;
            end
          end else begin
            sym_data_r  <= SYM_IDLE;
            sym_k_r     <= 1'b1;
            sym_lane_r  <= 2'd0;
            burst_cnt_r <= '0;
            idle_cnt_r  <= idle_next_s;
            idle_out_r  <= (idle_next_s >= IDLE_SAT);
          end
        end
        default: begin
          state_r <= ST_INIT;
        end
      endcase
    end else begin
      sym_valid_r <= 1'b0;
    end
  end

  assign sym_data  = sym_data_r;
  assign sym_k     = sym_k_r;
  assign sym_valid = sym_valid_r;
  assign sym_lane  = sym_lane_r;
  assign idle_out  = idle_out_r;

endmodule

// File: tb/tb_lane_tx_scheduler.sv
// Bench for lane_tx_scheduler: hand-derived vector table plus randomized traffic
// checked against a slot-level reference model of the scheduling rules.
module tb_lane_tx_scheduler;

  localparam int INIT_COM = 4;
  localparam int BURST    = 2;
  localparam int IDLE_MIN = 4;

  logic       clk_4f = 1'b0;
  logic       reset = 1'b1;
  logic       ser_ready = 1'b0;
  logic [7:0] data_0 = 8'h00, data_1 = 8'h00, data_2 = 8'h00, data_3 = 8'h00;
  logic       valid_0 = 1'b0, valid_1 = 1'b0, valid_2 = 1'b0, valid_3 = 1'b0;
  logic       ready_0, ready_1, ready_2, ready_3;
  logic [7:0] sym_data;
  logic       sym_k, sym_valid, idle_out;
  logic [1:0] sym_lane;

  always #5 clk_4f = ~clk_4f;

  lane_tx_scheduler #(.INIT_COM(INIT_COM), .BURST(BURST), .IDLE_MIN(IDLE_MIN)) dut (
    .clk_4f(clk_4f), .reset(reset),
    .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
    .ready_0(ready_0), .ready_1(ready_1), .ready_2(ready_2), .ready_3(ready_3),
    .ser_ready(ser_ready),
    .sym_data(sym_data), .sym_k(sym_k), .sym_valid(sym_valid),
    .sym_lane(sym_lane), .idle_out(idle_out)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] lane_data [4];

  // Reference model: training symbols sent, current priority lane, streak length, idle run
  bit         m_run   = 1'b0;
  int         m_com   = 0;
  int         m_ptr   = 0;
  int         m_burst = 0;
  int         m_idle  = 0;
  logic [7:0] e_data  = 8'h00;
  logic       e_k = 1'b0, e_sv = 1'b0, e_idl = 1'b0;
  logic [1:0] e_lane  = 2'd0;

  typedef struct {
    logic       rst;
    logic       sr;
    logic [3:0] vm;
    logic [7:0] d;
    logic       k;
    logic       sv;
    logic [1:0] lane;
    logic       idl;
    logic [3:0] rdy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic sr, input logic [3:0] vm, input logic [7:0] d,
                     input logic k, input logic sv, input logic [1:0] lane, input logic idl,
                     input logic [3:0] rdy);
    vec_t v;
    v.rst = rst; v.sr = sr; v.vm = vm; v.d = d; v.k = k;
    v.sv = sv; v.lane = lane; v.idl = idl; v.rdy = rdy;
    vq.push_back(v);
  endtask

  // One clock: drive inputs just after an edge, check ready mid-cycle, check symbols after the edge
  task automatic tick(input logic rst, input logic sr, input logic [3:0] vm, output logic [3:0] rdy_seen);
    int w;
    int n;
    logic [3:0] exp_rdy;
    reset = rst;
    ser_ready = sr;
    {valid_3, valid_2, valid_1, valid_0} = vm;
    data_0 = lane_data[0]; data_1 = lane_data[1];
    data_2 = lane_data[2]; data_3 = lane_data[3];
    w = -1;
    for (int k = 0; k < 4; k++) begin
      if (w < 0 && vm[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    end
    exp_rdy = 4'b0000;
    if (!rst && sr && m_run && w >= 0) exp_rdy[w] = 1'b1;
    #2;
    rdy_seen = {ready_3, ready_2, ready_1, ready_0};
    chk("ready", 32'(rdy_seen), 32'(exp_rdy));
    if (rst) begin
      m_run = 1'b0; m_com = 0; m_ptr = 0; m_burst = 0; m_idle = 0;
      e_data = 8'h00; e_k = 1'b0; e_sv = 1'b0; e_lane = 2'd0; e_idl = 1'b0;
    end else if (!sr) begin
      e_sv = 1'b0;
    end else if (!m_run) begin
      e_data = 8'hBC; e_k = 1'b1; e_sv = 1'b1; e_lane = 2'd0;
      m_com++;
      if (m_com == INIT_COM) m_run = 1'b1;
    end else if (w >= 0) begin
      e_data = lane_data[w]; e_k = 1'b0; e_sv = 1'b1; e_lane = 2'(w);
      e_idl = 1'b0; m_idle = 0;
      n = ((w == m_ptr) ? m_burst : 0) + 1;
      if (n == BURST) begin
        m_ptr = (w + 1) % 4; m_burst = 0;
      end else begin
        m_ptr = w; m_burst = n;
      end
    end else begin
      e_data = 8'h7C; e_k = 1'b1; e_sv = 1'b1; e_lane = 2'd0;
      m_burst = 0;
      if (m_idle < IDLE_MIN) m_idle++;
      e_idl = (m_idle >= IDLE_MIN);
    end
    @(posedge clk_4f);
    #1;
    chk("sym_data", 32'(sym_data), 32'(e_data));
    chk("sym_k", 32'(sym_k), 32'(e_k));
    chk("sym_valid", 32'(sym_valid), 32'(e_sv));
    chk("sym_lane", 32'(sym_lane), 32'(e_lane));
    chk("idle_out", 32'(idle_out), 32'(e_idl));
  endtask

  logic [3:0] rs;
  logic [3:0] pend;
  logic       rst_v, sr_v;

  initial begin
    lane_data[0] = 8'hFF; lane_data[1] = 8'hEE; lane_data[2] = 8'hDD; lane_data[3] = 8'hCC;

    // reset, COM burst, IDLE run with idle_out on the 4th IDLE
    add(1'b1, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 4'h0, 8'hBC, 1'b1, 1'b1, 2'd0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 4'h0, 8'h7C, 1'b1, 1'b1, 2'd0, 1'b0, 4'h0);
    add(1'b0, 1'b1, 4'h0, 8'h7C, 1'b1, 1'b1, 2'd0, 1'b1, 4'h0);
    // all lanes valid: 0,0,1,1,2,2,3,3,0
    add(1'b0, 1'b1, 4'hF, 8'hFF, 1'b0, 1'b1, 2'd0, 1'b0, 4'h1);
    add(1'b0, 1'b1, 4'hF, 8'hFF, 1'b0, 1'b1, 2'd0, 1'b0, 4'h1);
    add(1'b0, 1'b1, 4'hF, 8'hEE, 1'b0, 1'b1, 2'd1, 1'b0, 4'h2);
    add(1'b0, 1'b1, 4'hF, 8'hEE, 1'b0, 1'b1, 2'd1, 1'b0, 4'h2);
    add(1'b0, 1'b1, 4'hF, 8'hDD, 1'b0, 1'b1, 2'd2, 1'b0, 4'h4);
    add(1'b0, 1'b1, 4'hF, 8'hDD, 1'b0, 1'b1, 2'd2, 1'b0, 4'h4);
    add(1'b0, 1'b1, 4'hF, 8'hCC, 1'b0, 1'b1, 2'd3, 1'b0, 4'h8);
    add(1'b0, 1'b1, 4'hF, 8'hCC, 1'b0, 1'b1, 2'd3, 1'b0, 4'h8);
    add(1'b0, 1'b1, 4'hF, 8'hFF, 1'b0, 1'b1, 2'd0, 1'b0, 4'h1);
    // lane 2 twice to park the pointer on lane 3 with a fresh burst
    add(1'b0, 1'b1, 4'h4, 8'hDD, 1'b0, 1'b1, 2'd2, 1'b0, 4'h4);
    add(1'b0, 1'b1, 4'h4, 8'hDD, 1'b0, 1'b1, 2'd2, 1'b0, 4'h4);
    // lanes 0,3 from pointer 3: search wraps, grants 3,3,0,0
    add(1'b0, 1'b1, 4'h9, 8'hCC, 1'b0, 1'b1, 2'd3, 1'b0, 4'h8);
    add(1'b0, 1'b1, 4'h9, 8'hCC, 1'b0, 1'b1, 2'd3, 1'b0, 4'h8);
    add(1'b0, 1'b1, 4'h9, 8'hFF, 1'b0, 1'b1, 2'd0, 1'b0, 4'h1);
    add(1'b0, 1'b1, 4'h9, 8'hFF, 1'b0, 1'b1, 2'd0, 1'b0, 4'h1);
    // only lane 2: served every slot across burst wraps
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 4'h4, 8'hDD, 1'b0, 1'b1, 2'd2, 1'b0, 4'h4);
    // sparse strobes with lanes 1,3: outputs hold, sym_valid pulses, ready only on strobes
    add(1'b0, 1'b0, 4'hA, 8'hDD, 1'b0, 1'b0, 2'd2, 1'b0, 4'h0);
    add(1'b0, 1'b0, 4'hA, 8'hDD, 1'b0, 1'b0, 2'd2, 1'b0, 4'h0);
    add(1'b0, 1'b1, 4'hA, 8'hCC, 1'b0, 1'b1, 2'd3, 1'b0, 4'h8);
    add(1'b0, 1'b0, 4'hA, 8'hCC, 1'b0, 1'b0, 2'd3, 1'b0, 4'h0);
    add(1'b0, 1'b1, 4'hA, 8'hCC, 1'b0, 1'b1, 2'd3, 1'b0, 4'h8);
    add(1'b0, 1'b1, 4'hA, 8'hEE, 1'b0, 1'b1, 2'd1, 1'b0, 4'h2);
    // mid-burst reset: COM training restarts, lanes ignored for 4 strobes
    add(1'b1, 1'b1, 4'hA, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 4'hF, 8'hBC, 1'b1, 1'b1, 2'd0, 1'b0, 4'h0);
    add(1'b0, 1'b1, 4'hF, 8'hFF, 1'b0, 1'b1, 2'd0, 1'b0, 4'h1);

    @(posedge clk_4f);
    #1;
    foreach (vq[i]) begin
      tick(vq[i].rst, vq[i].sr, vq[i].vm, rs);
      chk("tbl_ready", 32'(rs), 32'(vq[i].rdy));
      chk("tbl_data", 32'(sym_data), 32'(vq[i].d));
      chk("tbl_k", 32'(sym_k), 32'(vq[i].k));
      chk("tbl_valid", 32'(sym_valid), 32'(vq[i].sv));
      chk("tbl_lane", 32'(sym_lane), 32'(vq[i].lane));
      chk("tbl_idle", 32'(idle_out), 32'(vq[i].idl));
    end

    // randomized traffic; valid held until accepted; second half uses 1-in-8 strobes on lanes 1,3
    pend = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (!pend[j] && ($urandom % 3 == 0) && (i < 300 || j == 1 || j == 3)) begin
          pend[j] = 1'b1;
          lane_data[j] = 8'($urandom);
        end
      end
      rst_v = ($urandom % 150 == 0);
      sr_v  = (i < 300) ? 1'($urandom % 2) : (i % 8 == 0);
      tick(rst_v, sr_v, pend, rs);
      pend = pend & ~rs;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
